// File: rtl/cmd_slot_packer.sv
// -----------------------------------------------------------------------------
// cmd_slot_packer
//
// Scheduler stage that sits directly upstream of the per-bank timing counters.
// It takes one DRAM command at a time from the request queue using a
// valid/ready handshake. The command is held until its bank's timing counter
// reports done. The command is then placed into the earliest legal DDR slot of
// the nCK_PER_CLK-wide PHY command word. ACT and PRE also restart that bank's
// timing counter with the chosen slot.
//
// Optional feature (build macro CMD_STALL_TIMEOUT_EN): a WAIT-cycle stall
// counter. It raises a sticky o_stall_err once a command has waited
// STALL_LIMIT non-eligible cycles. Without the macro, o_stall_err is tied to 0.
//
// Ports
//   i_clk          fabric clock
//   i_rst          asynchronous reset, active low (asserted when 0)
//   i_cmd_valid    request present
//   o_cmd_ready    block can capture a request (depends on state only)
//   i_cmd_type     0=NOP 1=ACT 2=PRE 3=RD 4=WR, 5..7 treated as NOP
//   i_cmd_bank     target bank
//   i_cmd_addr     row (ACT) or column (RD/WR) address
//   i_bank_done    per-bank timing counter done
//   i_bank_offset  per-bank earliest legal slot, bank b at [b*SW +: SW]
//   o_phy_valid    phy_* outputs carry a command word this cycle
//   o_phy_cmd      per-slot command code, slot s at [s*3 +: 3]
//   o_phy_bank     bank of the issued command
//   o_phy_addr     address of the issued command
//   o_tc_start     one-hot, single-cycle counter restart pulse
//   o_tc_slot      slot value passed along with o_tc_start
//   o_stall_err    sticky stall timeout flag
// -----------------------------------------------------------------------------
module cmd_slot_packer #(
  parameter int unsigned nCK_PER_CLK = 4,
  parameter int unsigned NUM_BANKS   = 8,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_cmd_valid,
  output logic                                      o_cmd_ready,
  input  logic [2:0]                                i_cmd_type,
  input  logic [$clog2(NUM_BANKS)-1:0]              i_cmd_bank,
  input  logic [ADDR_W-1:0]                         i_cmd_addr,
  input  logic [NUM_BANKS-1:0]                      i_bank_done,
  input  logic [NUM_BANKS*$clog2(nCK_PER_CLK)-1:0]  i_bank_offset,
  output logic                                      o_phy_valid,
  output logic [3*nCK_PER_CLK-1:0]                  o_phy_cmd,
  output logic [$clog2(NUM_BANKS)-1:0]              o_phy_bank,
  output logic [ADDR_W-1:0]                         o_phy_addr,
  output logic [NUM_BANKS-1:0]                      o_tc_start,
  output logic [$clog2(nCK_PER_CLK)-1:0]            o_tc_slot,
  output logic                                      o_stall_err
);

  localparam int unsigned SW = $clog2(nCK_PER_CLK);
  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned CW = 3 * nCK_PER_CLK;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  // State and holding register
  logic [0:0]        r_state;
  logic              r_live;  // low in reset, so ready stays low until the first edge
  logic [2:0]        r_type;
  logic [BW-1:0]     r_bank;
  logic [ADDR_W-1:0] r_addr;

  // Registered outputs
  logic                 r_phy_valid;
  logic [CW-1:0]        r_phy_cmd;
  logic [BW-1:0]        r_phy_bank;
  logic [ADDR_W-1:0]    r_phy_addr;
  logic [NUM_BANKS-1:0] r_tc_start;
  logic [SW-1:0]        r_tc_slot;

  // Next-state / decode
  logic                 w_accept;
  logic                 w_is_nop;
  logic                 w_restart;
  logic                 w_eligible;
  logic                 w_issue;
  logic [SW-1:0]        w_slot;
  logic [2:0]           w_code;
  logic [CW-1:0]        w_phy_cmd;
  logic [NUM_BANKS-1:0] w_onehot;

  assign o_cmd_ready = r_live && (r_state == ST_IDLE);
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  always_comb begin
    w_is_nop  = 1'b1;
    w_restart = 1'b0;
    unique case (r_type)
      CMD_ACT, CMD_PRE: begin
        w_is_nop  = 1'b0;
        w_restart = 1'b1;
      end
      CMD_RD, CMD_WR: w_is_nop = 1'b0;
      default: w_is_nop = 1'b1;
    endcase
  end

  // NOP-class commands never wait on the bank counter.
  assign w_eligible = (r_state == ST_WAIT) && (w_is_nop || i_bank_done[r_bank]);
  assign w_issue    = w_eligible;

  assign w_code = w_is_nop ? CMD_NOP : r_type;
  assign w_slot = w_is_nop ? '0 : i_bank_offset[int'(r_bank)*SW +: SW];

  always_comb begin
    w_phy_cmd = '0;
    for (int s = 0; s < int'(nCK_PER_CLK); s++) begin
      if (w_slot == SW'(s)) begin
        w_phy_cmd[s*3 +: 3] = w_code;
      end
    end
  end

  assign w_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << r_bank;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_type  <= CMD_NOP;
      r_bank  <= '0;
      r_addr  <= '0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_type  <= i_cmd_type;
            r_bank  <= i_cmd_bank;
            r_addr  <= i_cmd_addr;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_issue) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs hold a word for exactly one cycle after issue. They read 0 at all
  // other times.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_phy_valid <= 1'b0;
      r_phy_cmd   <= '0;
      r_phy_bank  <= '0;
      r_phy_addr  <= '0;
      r_tc_start  <= '0;
      r_tc_slot   <= '0;
    end else if (w_issue) begin
      r_phy_valid <= 1'b1;
      r_phy_cmd   <= w_phy_cmd;
      r_phy_bank  <= r_bank;
      r_phy_addr  <= r_addr;
      r_tc_start  <= w_restart ? w_onehot : '0;
      r_tc_slot   <= w_restart ? w_slot : '0;
    end else begin
      r_phy_valid <= 1'b0;
      r_phy_cmd   <= '0;
      r_phy_bank  <= '0;
      r_phy_addr  <= '0;
      r_tc_start  <= '0;
      r_tc_slot   <= '0;
    end
  end

  assign o_phy_valid = r_phy_valid;
  assign o_phy_cmd   = r_phy_cmd;
  assign o_phy_bank  = r_phy_bank;
  assign o_phy_addr  = r_phy_addr;
  assign o_tc_start  = r_tc_start;
  assign o_tc_slot   = r_tc_slot;

`ifdef CMD_STALL_TIMEOUT_EN
  localparam int unsigned STW = $clog2(STALL_LIMIT + 1);

  logic [STW-1:0] r_stall_cnt;
  logic [STW-1:0] w_stall_cnt_d;
  logic           r_stall_err;
  logic           w_stalled;

  assign w_stalled = (r_state == ST_WAIT) && !w_eligible;

  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (w_accept) begin
      w_stall_cnt_d = '0;
    end else if (w_stalled && (r_stall_cnt != STW'(STALL_LIMIT))) begin
      w_stall_cnt_d = r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_d;
      // The flag sets on the edge where the counter reaches the limit. The
      // held command keeps waiting.
      if (w_stalled && (w_stall_cnt_d == STW'(STALL_LIMIT))) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign o_stall_err = r_stall_err;
`else
  logic w_unused_stall;
  assign w_unused_stall = (STALL_LIMIT == 0);
  assign o_stall_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_slot_packer.sv
// -----------------------------------------------------------------------------
// tb_cmd_slot_packer
//
// Directed bench for cmd_slot_packer. Expected values are hand-computed
// constants. Inputs change 1 time unit after the rising edge, and outputs are
// checked at the same point.
// -----------------------------------------------------------------------------
module tb_cmd_slot_packer;

  localparam int unsigned NCK = 4;
  localparam int unsigned NB  = 8;
  localparam int unsigned AW  = 14;

`ifdef CMD_STALL_TIMEOUT_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_type;
  logic [2:0]    cmd_bank;
  logic [AW-1:0] cmd_addr;
  logic [NB-1:0] bank_done;
  logic [15:0]   bank_offset;
  logic          phy_valid;
  logic [11:0]   phy_cmd;
  logic [2:0]    phy_bank;
  logic [AW-1:0] phy_addr;
  logic [NB-1:0] tc_start;
  logic [1:0]    tc_slot;
  logic          stall_err;

  int total = 0;
  int bad   = 0;

  cmd_slot_packer #(
    .nCK_PER_CLK (NCK),
    .NUM_BANKS   (NB),
    .ADDR_W      (AW),
    .STALL_LIMIT (4)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_type    (cmd_type),
    .i_cmd_bank    (cmd_bank),
    .i_cmd_addr    (cmd_addr),
    .i_bank_done   (bank_done),
    .i_bank_offset (bank_offset),
    .o_phy_valid   (phy_valid),
    .o_phy_cmd     (phy_cmd),
    .o_phy_bank    (phy_bank),
    .o_phy_addr    (phy_addr),
    .o_tc_start    (tc_start),
    .o_tc_slot     (tc_slot),
    .o_stall_err   (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return just after the accepting edge.
  task automatic send(input logic [2:0] t, input logic [2:0] b, input logic [AW-1:0] a);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_bank  = b;
    cmd_addr  = a;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic check_idle_out(input string tag);
    check({tag, ".pv"},  {31'd0, phy_valid}, 32'd0);
    check({tag, ".cmd"}, {20'd0, phy_cmd},   32'd0);
    check({tag, ".tc"},  {24'd0, tc_start},  32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_type    = 3'd0;
    cmd_bank    = 3'd0;
    cmd_addr    = '0;
    bank_done   = '0;
    bank_offset = '0;

    // Reset held: ready low, outputs zero
    #2;
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_idle_out("rst");
    step();
    check("rst_ready_edge", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    step();
    check("rel_ready", {31'd0, cmd_ready}, 32'd1);
    check_idle_out("rel");
    check("rel_bank", {29'd0, phy_bank}, 32'd0);
    check("rel_addr", {18'd0, phy_addr}, 32'd0);
    check("rel_slot", {30'd0, tc_slot},  32'd0);
    check("rel_stall", {31'd0, stall_err}, 32'd0);

    // ACT bank 2 at slot 3: code 1 at bits [11:9]
    bank_done   = 8'h04;
    bank_offset = 16'h0030;
    send(3'd1, 3'd2, 14'h1A5);
    check("act_ready_wait", {31'd0, cmd_ready}, 32'd0);
    check("act_pv_early", {31'd0, phy_valid}, 32'd0);
    step();
    check("act_pv",   {31'd0, phy_valid}, 32'd1);
    check("act_cmd",  {20'd0, phy_cmd},   32'h200);
    check("act_bank", {29'd0, phy_bank},  32'd2);
    check("act_addr", {18'd0, phy_addr},  32'h1A5);
    check("act_tc",   {24'd0, tc_start},  32'h04);
    check("act_slot", {30'd0, tc_slot},   32'd3);
    check("act_ready_back", {31'd0, cmd_ready}, 32'd1);
    step();
    check_idle_out("act_after");

    // RD bank 5 blocked for 6 cycles, then done with offset 1
    bank_done   = 8'h00;
    bank_offset = 16'h0000;
    send(3'd3, 3'd5, 14'h02C);
    for (int i = 0; i < 6; i++) begin
      check("rd_hold_ready", {31'd0, cmd_ready}, 32'd0);
      check("rd_hold_pv",    {31'd0, phy_valid}, 32'd0);
      step();
    end
    bank_done   = 8'h20;
    bank_offset = 16'h0400;
    step();
    check("rd_pv",   {31'd0, phy_valid}, 32'd1);
    check("rd_cmd",  {20'd0, phy_cmd},   32'h018);
    check("rd_bank", {29'd0, phy_bank},  32'd5);
    check("rd_addr", {18'd0, phy_addr},  32'h02C);
    check("rd_tc",   {24'd0, tc_start},  32'd0);
    check("rd_slot", {30'd0, tc_slot},   32'd0);
    step();

    // Back-to-back PRE bank0 then WR bank1, valid held high
    bank_done   = 8'hFF;
    bank_offset = 16'h0000;
    cmd_valid   = 1'b1;
    cmd_type    = 3'd2;
    cmd_bank    = 3'd0;
    cmd_addr    = 14'h010;
    step();
    cmd_type = 3'd4;
    cmd_bank = 3'd1;
    cmd_addr = 14'h033;
    check("b2b_ready0", {31'd0, cmd_ready}, 32'd0);
    check("b2b_pv0",    {31'd0, phy_valid}, 32'd0);
    step();
    check("pre_pv",   {31'd0, phy_valid}, 32'd1);
    check("pre_cmd",  {20'd0, phy_cmd},   32'h002);
    check("pre_bank", {29'd0, phy_bank},  32'd0);
    check("pre_tc",   {24'd0, tc_start},  32'h01);
    check("pre_slot", {30'd0, tc_slot},   32'd0);
    check("b2b_ready1", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("b2b_pv_gap", {31'd0, phy_valid}, 32'd0);
    check("b2b_ready2", {31'd0, cmd_ready}, 32'd0);
    step();
    check("wr_pv",   {31'd0, phy_valid}, 32'd1);
    check("wr_cmd",  {20'd0, phy_cmd},   32'h004);
    check("wr_bank", {29'd0, phy_bank},  32'd1);
    check("wr_addr", {18'd0, phy_addr},  32'h033);
    check("wr_tc",   {24'd0, tc_start},  32'd0);
    step();
    check("wr_after_pv", {31'd0, phy_valid}, 32'd0);

    // Type 6 to bank 3 with the bank not done: issues as NOP
    bank_done = 8'h00;
    send(3'd6, 3'd3, 14'h0AA);
    step();
    check("nop_pv",   {31'd0, phy_valid}, 32'd1);
    check("nop_cmd",  {20'd0, phy_cmd},   32'd0);
    check("nop_bank", {29'd0, phy_bank},  32'd3);
    check("nop_tc",   {24'd0, tc_start},  32'd0);
    step();

    // Stall then reset in the middle of WAIT
    bank_done = 8'h00;
    send(3'd1, 3'd6, 14'h123);
    for (int i = 0; i < 5; i++) begin
      check("stall_pv", {31'd0, phy_valid}, 32'd0);
      step();
    end
    check("stall_err", {31'd0, stall_err}, {31'd0, STALL_EN});
    step();
    check("stall_sticky", {31'd0, stall_err}, {31'd0, STALL_EN});
    check("stall_ready",  {31'd0, cmd_ready}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_err}, 32'd0);
    check_idle_out("mid_rst");
    step();
    bank_done = 8'hFF;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_pv",    {31'd0, phy_valid}, 32'd0);
      check("drop_tc",    {24'd0, tc_start},  32'd0);
      check("drop_ready", {31'd0, cmd_ready}, 32'd1);
    end

    // WR bank 7 at slot 2 after recovery: code 4 at bits [8:6]
    bank_offset = 16'h8000;
    send(3'd4, 3'd7, 14'h3FFF);
    step();
    check("wr7_pv",   {31'd0, phy_valid}, 32'd1);
    check("wr7_cmd",  {20'd0, phy_cmd},   32'h100);
    check("wr7_bank", {29'd0, phy_bank},  32'd7);
    check("wr7_addr", {18'd0, phy_addr},  32'h3FFF);
    check("wr7_tc",   {24'd0, tc_start},  32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
